input_pingpong_buffer: RTL and testbench

//  Double-buffered (ping-pong), banked input feature-map memory for the CNN datapath.
//  A streaming write port scatters incoming words round-robin across NUM_BANKS banks of the fill page.
//  The compute engine reads the other (full) page through independent per-bank read ports.

---
 rtl/input_pingpong_buffer.sv | 76 +++++++
 tb/tb_input_pingpong_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/input_pingpong_buffer.sv
// input_pingpong_buffer: two-page banked input buffer with round-robin stream fill and per-bank reads
module input_pingpong_buffer #(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 1024,
  localparam int ADDR_WIDTH = $clog2(BANK_DEPTH),
  localparam int CNT_WIDTH  = $clog2(NUM_BANKS*BANK_DEPTH)+1
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_wr_valid,
  output logic                             o_wr_ready,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic                             i_wr_last,
  output logic                             o_page_ready,
  output logic [CNT_WIDTH-1:0]             o_page_words,
  input  logic                             i_page_release,
  input  logic [NUM_BANKS-1:0]             i_rd_enable,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  i_rd_address,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  o_rd_data,
  output logic [NUM_BANKS-1:0]             o_rd_valid
);
  localparam int CAP = NUM_BANKS*BANK_DEPTH;
  logic wp, rp;
  logic [1:0] full;
  logic [CNT_WIDTH-1:0] wcnt, wbank, wrow;
  logic [CNT_WIDTH-1:0] words [2];
  logic accept, close, release_pg;
  assign o_wr_ready   = !full[wp];
  assign o_page_ready = full[rp];
  assign o_page_words = full[rp] ? words[rp] : '0;
  assign accept       = i_wr_valid & o_wr_ready;
  assign close        = accept & (i_wr_last | (wcnt == CNT_WIDTH'(CAP-1)));
  assign release_pg   = i_page_release & full[rp];
  assign wbank        = wcnt % CNT_WIDTH'(NUM_BANKS);
  assign wrow         = wcnt / CNT_WIDTH'(NUM_BANKS);
  // close only touches the empty fill page and release only the full read page, so they never collide
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wp       <= 1'b0;
      rp       <= 1'b0;
      full     <= 2'b00;
      wcnt     <= '0;
      words[0] <= '0;
      words[1] <= '0;
    end else begin
      if (accept) wcnt <= close ? '0 : wcnt + 1'b1;
      if (close) begin
        full[wp]  <= 1'b1;
        words[wp] <= wcnt + 1'b1;
        wp        <= ~wp;
      end
      if (release_pg) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
      end
    end
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [2*BANK_DEPTH];
    logic rd_en;
    assign rd_en = i_rd_enable[b] & full[rp];
    always_ff @(posedge i_clock) begin
      if (accept && wbank == CNT_WIDTH'(b)) mem[{wp, wrow[ADDR_WIDTH-1:0]}] <= i_wr_data;
    end
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        o_rd_valid[b]                     <= 1'b0;
        o_rd_data[b*DATA_WIDTH+:DATA_WIDTH] <= '0;
      end else begin
        o_rd_valid[b] <= rd_en;
        if (rd_en) o_rd_data[b*DATA_WIDTH+:DATA_WIDTH] <= mem[{rp, i_rd_address[b*ADDR_WIDTH+:ADDR_WIDTH]}];
      end
    end
  end
endmodule

// File: tb/tb_input_pingpong_buffer.sv
// tb_input_pingpong_buffer: directed scenarios plus random traffic checked against a tile-queue model
module tb_input_pingpong_buffer;
  localparam int NB = 4, DW = 32, BD = 4, AW = 2, CW = 5, CAP = NB*BD;
  logic clk = 0, rst = 1;
  logic wr_valid = 0, wr_ready, wr_last = 0, page_ready, page_release = 0;
  logic [DW-1:0] wr_data = 0;
  logic [CW-1:0] page_words;
  logic [NB-1:0] rd_enable = 0, rd_valid;
  logic [NB*AW-1:0] rd_address = 0;
  logic [NB*DW-1:0] rd_data;
  always #5 clk = ~clk;
  input_pingpong_buffer #(.NUM_BANKS(NB), .DATA_WIDTH(DW), .BANK_DEPTH(BD)) dut (
    .i_clock(clk), .i_reset(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_data(wr_data), .i_wr_last(wr_last), .o_page_ready(page_ready),
    .o_page_words(page_words), .i_page_release(page_release), .i_rd_enable(rd_enable),
    .i_rd_address(rd_address), .o_rd_data(rd_data), .o_rd_valid(rd_valid));
  int n_vec = 0, n_bad = 0;
  logic [DW-1:0] mm [2][CAP];
  bit wf [2][CAP];
  int qp[$], qw[$];
  int fp, fc;
  logic [NB-1:0] ev;
  logic [DW-1:0] ed [NB];
  bit dk [NB];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1; wr_valid = 0; wr_last = 0; page_release = 0; rd_enable = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    qp.delete(); qw.delete(); fp = 0; fc = 0; ev = '0;
    for (int b = 0; b < NB; b++) begin ed[b] = '0; dk[b] = 1; end
    check("rst_wr_ready", wr_ready, 1);
    check("rst_page_ready", page_ready, 0);
    check("rst_page_words", page_words, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
  endtask
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic rel,
                       input logic [NB-1:0] en, input logic [NB*AW-1:0] ad);
    bit rdy;
    int hp, k;
    wr_valid = v; wr_data = d; wr_last = l; page_release = rel; rd_enable = en; rd_address = ad;
    #1;
    check("wr_ready", wr_ready, qp.size() < 2);
    check("page_ready", page_ready, qp.size() > 0);
    check("page_words", page_words, qp.size() > 0 ? qw[0] : 0);
    rdy = qp.size() > 0;
    hp = rdy ? qp[0] : 0;
    for (int b = 0; b < NB; b++) begin
      ev[b] = en[b] && rdy;
      if (ev[b]) begin
        k = int'(ad[b*AW+:AW])*NB + b;
        ed[b] = mm[hp][k];
        dk[b] = wf[hp][k];
      end
    end
    if (v && qp.size() < 2) begin
      mm[fp][fc] = d; wf[fp][fc] = 1;
      if (l || fc == CAP-1) begin
        qp.push_back(fp); qw.push_back(fc+1); fp ^= 1; fc = 0;
      end else fc++;
    end
    if (rel && rdy) begin
      void'(qp.pop_front()); void'(qw.pop_front());
    end
    @(posedge clk); #1;
    check("rd_valid", rd_valid, ev);
    for (int b = 0; b < NB; b++)
      if (dk[b]) check($sformatf("rd_data%0d", b), rd_data[b*DW+:DW], ed[b]);
  endtask
  initial begin
    do_reset();
    for (int i = 1; i <= 10; i++) cycle(1, i, i == 10, 0, 0, 0);
    check("t1_page_ready", page_ready, 1);
    check("t1_page_words", page_words, 10);
    cycle(0, 0, 0, 0, 4'b0011, 8'b0000_0000);
    check("t1_b0a0_b1a0", rd_data[63:0], {32'd2, 32'd1});
    cycle(0, 0, 0, 0, 4'b0011, 8'b0000_1010);
    check("t1_b0a2_b1a2", rd_data[63:0], {32'd10, 32'd9});
    cycle(0, 0, 0, 0, 4'b1111, 8'b0101_0101);
    check("t2_valid", rd_valid, 4'hF);
    check("t2_data", rd_data, {32'd8, 32'd7, 32'd6, 32'd5});
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 32; i++) cycle(1, i, 0, 0, 0, 0);
    check("t3_stall", wr_ready, 0);
    repeat (3) cycle(1, 33, 0, 0, 0, 0);
    cycle(1, 33, 0, 1, 4'b0001, 0);
    check("t4_first_page_b0a0", rd_data[31:0], 1);
    check("t4_ready_after_release", wr_ready, 1);
    check("t4_page_words", page_words, 16);
    cycle(1, 33, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("t5_no_page", page_ready, 0);
    cycle(0, 0, 0, 0, 4'b1111, 0);
    check("t5_rd_valid", rd_valid, 0);
    cycle(1, 34, 0, 0, 0, 0);
    cycle(1, 35, 0, 0, 0, 0);
    do_reset();
    cycle(1, 50, 0, 0, 0, 0);
    cycle(1, 51, 1, 0, 0, 0);
    check("t6_page_words", page_words, 2);
    cycle(0, 0, 0, 0, 4'b0011, 0);
    check("t6_b0a0_b1a0", rd_data[63:0], {32'd51, 32'd50});
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 4) == 0), 4'($urandom), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
